rx_deserializer: RTL

- Receive-side stage directly downstream of the 10-bit LSB-first serial transmitter.
- Samples the serial line every clock and reassembles each 10-bit frame, using the transmitter's one-cycle done strobe as the frame marker.
- Pushes each frame into a small first-word-fall-through buffer with a valid/ready output handshake toward the counting/display logic.
- Keeps a count of accepted frames and a sticky overflow flag.

---
 rtl/rx_deserializer_pkg.sv | 8 +
 rtl/sync_fifo_fwft.sv | 53 +++++
 rtl/rx_deserializer.sv | 68 ++++++
 3 files changed

// File: rtl/rx_deserializer_pkg.sv
// Shared frame definitions for the serial link: transmitter wrapper, receiver and counter stage.
package rx_deserializer_pkg;

    localparam int unsigned FRAME_BITS = 10;

    typedef logic [FRAME_BITS-1:0] frame_t;

endpackage

// File: rtl/sync_fifo_fwft.sv
// Synchronous first-word-fall-through FIFO; a pointer wrap bit distinguishes full from empty.
module sync_fifo_fwft #(
    parameter int unsigned DATA_W     = 10,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                        i_clk,
    input  logic                        i_rst,
    input  logic                        i_push,
    input  logic                        i_pop,
    input  logic [DATA_W-1:0]           i_wdata,
    output logic [DATA_W-1:0]           o_rdata_c,
    output logic [$clog2(FIFO_DEPTH):0] o_level_c,
    output logic                        o_full_c,
    output logic                        o_empty_c
);

    localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH) + 1;
    localparam int unsigned ADDR_W = PTR_W - 1;

    logic [DATA_W-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic              do_push;
    logic              do_pop;

    assign o_empty_c = (wr_ptr == rd_ptr);
    assign o_full_c  = ((wr_ptr ^ rd_ptr) == {1'b1, {ADDR_W{1'b0}}});
    assign o_level_c = wr_ptr - rd_ptr;
    assign o_rdata_c = mem[rd_ptr[ADDR_W-1:0]];

    // A push into a full FIFO is allowed only when the head slot is being freed on the same edge.
    assign do_pop  = i_pop && !o_empty_c;
    assign do_push = i_push && (!o_full_c || do_pop);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem[wr_ptr[ADDR_W-1:0]] <= i_wdata;
                wr_ptr                  <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
        end
    end

endmodule

// File: rtl/rx_deserializer.sv
// Reassembles LSB-first serial frames marked by the transmitter's done strobe and buffers them
// behind a valid/ready handshake, counting accepted frames and flagging drops.
module rx_deserializer
    import rx_deserializer_pkg::*;
#(
    parameter int unsigned DATA_W     = FRAME_BITS,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned CNT_W      = 16
) (
    input  logic                        i_clk,
    input  logic                        i_rst,
    input  logic                        i_serial,
    input  logic                        i_tx_done,
    output logic [DATA_W-1:0]           o_data,
    output logic                        o_valid,
    input  logic                        i_ready,
    output logic [$clog2(FIFO_DEPTH):0] o_level,
    output logic [CNT_W-1:0]            o_frame_cnt,
    output logic                        o_overflow
);

    // Only the DATA_W-1 most recent bits are kept; the live line bit completes the frame.
    logic [DATA_W-2:0] sr;
    logic [DATA_W-1:0] frame_c;
    logic              full_c;
    logic              empty_c;
    logic              pop_c;
    logic              accept_c;
    logic              drop_c;

    assign frame_c  = {i_serial, sr};
    assign o_valid  = !empty_c;
    assign pop_c    = o_valid && i_ready;
    assign accept_c = i_tx_done && (!full_c || pop_c);
    assign drop_c   = i_tx_done && full_c && !pop_c;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            sr          <= '0;
            o_frame_cnt <= '0;
            o_overflow  <= 1'b0;
        end else begin
            sr <= frame_c[DATA_W-1:1];
            if (accept_c) begin
                o_frame_cnt <= o_frame_cnt + CNT_W'(1);
            end
            if (drop_c) begin
                o_overflow <= 1'b1;
            end
        end
    end

    sync_fifo_fwft #(
        .DATA_W     (DATA_W),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_push    (accept_c),
        .i_pop     (pop_c),
        .i_wdata   (frame_c),
        .o_rdata_c (o_data),
        .o_level_c (o_level),
        .o_full_c  (full_c),
        .o_empty_c (empty_c)
    );

endmodule
